// File: rtl/fp16_divider_iterative.sv
// FP16 (1/5/10, bias 15) divider: restoring division, one quotient bit per clock, with RNE rounding.
// Saturates to SAT_VALUE on overflow and on divide-by-zero, and flushes underflow to zero.
module fp16_divider_iterative #(
    parameter int          BIAS      = 15,
    parameter logic [15:0] SAT_VALUE = 16'h7F80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    localparam logic signed [7:0] BIAS_S = BIAS[7:0];

    state_t             state_reg, state_next;
    logic [12:0]        rem_reg, q_reg;
    logic [10:0]        mb_reg;
    logic [3:0]         cnt_reg;
    logic signed [7:0]  exp_reg;
    logic               sign_reg, special_reg, dbz_reg;

    // operand decode (exponent 0 covers both zero and flushed subnormals)
    logic               a_zero, b_zero, ma_lt;
    logic [10:0]        ma, mb;
    logic signed [7:0]  exp_calc;
    logic [12:0]        dividend;

    assign a_zero   = (a[14:10] == 5'd0);
    assign b_zero   = (b[14:10] == 5'd0);
    assign ma       = {1'b1, a[9:0]};
    assign mb       = {1'b1, b[9:0]};
    assign ma_lt    = (ma < mb);
    assign exp_calc = $signed({3'b000, a[14:10]}) - $signed({3'b000, b[14:10]}) + BIAS_S
                      - (ma_lt ? 8'sd1 : 8'sd0);
    assign dividend = ma_lt ? {1'b0, ma, 1'b0} : {2'b00, ma};

    // one restoring step
    logic               rem_ge;
    logic [12:0]        rem_sel, rem_step;

    assign rem_ge   = (rem_reg >= {2'b00, mb_reg});
    assign rem_sel  = rem_ge ? (rem_reg - {2'b00, mb_reg}) : rem_reg;
    assign rem_step = rem_sel << 1;

    // round to nearest even; q[1] guard, q[0] round, leftover remainder is sticky
    logic               sticky, round_up;
    logic [11:0]        m;
    logic signed [7:0]  exp_rnd;
    logic [9:0]         frac;

    assign sticky   = |rem_reg;
    assign round_up = q_reg[1] & (q_reg[0] | sticky | q_reg[2]);
    assign m        = {1'b0, q_reg[12:2]} + {11'd0, round_up};
    assign exp_rnd  = exp_reg + (m[11] ? 8'sd1 : 8'sd0);
    assign frac     = m[11] ? m[10:1] : m[9:0];

    assign in_ready = (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // zero and divide-by-zero operands skip DIVIDE and are resolved in ROUND
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = (a_zero || b_zero) ? ROUND : DIVIDE;
            DIVIDE:  if (cnt_reg == 4'd12) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg     <= '0;
            q_reg       <= '0;
            mb_reg      <= '0;
            cnt_reg     <= '0;
            exp_reg     <= '0;
            sign_reg    <= 1'b0;
            special_reg <= 1'b0;
            dbz_reg     <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg    <= a[15] ^ b[15];
                        special_reg <= a_zero | b_zero;
                        dbz_reg     <= b_zero;
                        exp_reg     <= exp_calc;
                        rem_reg     <= dividend;
                        mb_reg      <= mb;
                        q_reg       <= '0;
                        cnt_reg     <= '0;
                    end
                end
                DIVIDE: begin
                    rem_reg <= rem_step;
                    q_reg   <= {q_reg[11:0], rem_ge};
                    cnt_reg <= cnt_reg + 4'd1;
                end
                ROUND: begin
                    out_valid <= 1'b1;
                    if (special_reg) begin
                        result      <= dbz_reg ? SAT_VALUE : 16'h0000;
                        div_by_zero <= dbz_reg;
                    end else if (exp_rnd >= 8'sd31) begin
                        result   <= SAT_VALUE;
                        overflow <= 1'b1;
                    end else if (exp_rnd <= 8'sd0) begin
                        result    <= 16'h0000;
                        underflow <= 1'b1;
                    end else begin
                        result <= {sign_reg, exp_rnd[4:0], frac};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_divider_iterative.sv
// Testbench for fp16_divider_iterative: directed spec cases, backpressure, mid-op reset,
// and random operands checked against an exact integer-division reference.
module tb_fp16_divider_iterative;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        overflow, underflow, div_by_zero;
    logic [15:0] a, b, result;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp16_divider_iterative dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {overflow, underflow, div_by_zero, result}. Quotient is the exact ratio of the
    // significands scaled to 11 bits, rounded to nearest even via integer quotient/remainder.
    function automatic logic [18:0] model(input logic [15:0] av, input logic [15:0] bv);
        int ea, eb, ma, mb, num, qi, r, e;
        logic s;
        ea = int'(av[14:10]);
        eb = int'(bv[14:10]);
        if (eb == 0) return {3'b001, 16'h7F80};
        if (ea == 0) return {3'b000, 16'h0000};
        ma = 1024 + int'(av[9:0]);
        mb = 1024 + int'(bv[9:0]);
        e  = ea - eb + 15;
        num = ma * 1024;
        if (ma < mb) begin
            num = ma * 2048;
            e   = e - 1;
        end
        qi = num / mb;
        r  = num % mb;
        if (2 * r > mb || (2 * r == mb && (qi % 2) == 1)) qi = qi + 1;
        if (qi == 2048) begin
            qi = 1024;
            e  = e + 1;
        end
        if (e >= 31) return {3'b100, 16'h7F80};
        if (e <= 0)  return {3'b010, 16'h0000};
        s = av[15] ^ bv[15];
        return {3'b000, s, e[4:0], qi[9:0]};
    endfunction

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [18:0] expv, input bit hold);
        int wait_n, lat, lat_exp;
        logic [15:0] held;
        wait_n = 0;
        while (!in_ready && wait_n < 50) begin
            step();
            wait_n++;
        end
        if (!in_ready) check({tag, " in_ready_timeout"}, 32'(in_ready), 32'd1);
        out_ready = !hold;
        a = av;
        b = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        lat_exp = (av[14:10] == 5'd0 || bv[14:10] == 5'd0) ? 1 : 14;
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " result"}, 32'(result), 32'(expv[15:0]));
        check({tag, " flags"}, 32'({overflow, underflow, div_by_zero}), 32'(expv[18:16]));
        $display("op %s a=%h b=%h result=%h flags=%b latency=%0d", tag, av, bv, result,
                 {overflow, underflow, div_by_zero}, lat);
        held = result;
        if (hold) begin
            for (int i = 0; i < 20; i++) begin
                in_valid = 1'b1;
                a = 16'h4400;
                b = 16'h3C00;
                step();
                check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
                check({tag, " hold result"}, 32'(result), 32'(held));
                check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        step();
        check({tag, " released out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " released in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " released flags"}, 32'({overflow, underflow, div_by_zero}), 32'd0);
        check({tag, " result held"}, 32'(result), 32'(held));
    endtask

    initial begin
        int seen;
        logic [15:0] ra, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (3) step();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'({overflow, underflow, div_by_zero}), 32'd0);
        rst = 1'b0;
        step();

        run_op("3/1.5",      16'h4200, 16'h3E00, {3'b000, 16'h4000}, 1'b0);
        run_op("1/3",        16'h3C00, 16'h4200, {3'b000, 16'h3555}, 1'b0);
        run_op("-3/1.5",     16'hC200, 16'h3E00, {3'b000, 16'hC000}, 1'b0);
        run_op("overflow",   16'h7800, 16'h0400, {3'b100, 16'h7F80}, 1'b0);
        run_op("underflow",  16'h0400, 16'h7800, {3'b010, 16'h0000}, 1'b0);
        run_op("div0",       16'h3C00, 16'h0000, {3'b001, 16'h7F80}, 1'b0);
        run_op("0/0",        16'h0000, 16'h0000, {3'b001, 16'h7F80}, 1'b0);
        run_op("subnorm_b",  16'h3C00, 16'h0123, {3'b001, 16'h7F80}, 1'b0);
        run_op("zero_a",     16'h0000, 16'h4000, {3'b000, 16'h0000}, 1'b0);
        run_op("backpress",  16'h3C00, 16'h4200, {3'b000, 16'h3555}, 1'b1);

        // reset during DIVIDE iteration 6
        out_ready = 1'b1;
        a = 16'h4200;
        b = 16'h3E00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset result", 32'(result), 32'd0);
        check("midreset flags", 32'({overflow, underflow, div_by_zero}), 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("midreset stale out_valid", 32'(seen), 32'd0);
        $display("op midreset out_valid_seen=%0d", seen);
        run_op("rerun 3/1.5", 16'h4200, 16'h3E00, {3'b000, 16'h4000}, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) begin
                ra = {1'($urandom), 5'($urandom_range(22, 8)), 10'($urandom)};
                rb = {1'($urandom), 5'($urandom_range(22, 8)), 10'($urandom)};
            end else begin
                ra = 16'($urandom);
                rb = 16'($urandom);
            end
            run_op($sformatf("rand%0d", i), ra, rb, model(ra, rb), (i % 15) == 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
